uart_fifo_core: RTL

Parametrised UART core with TX and RX FIFOs. It is the next-generation replacement for the fixed 8N1 UART inside the sensor-driver soft system.
- Configurable frame format: data bits, parity, stop bits.
- Configurable baud divisor, 16x oversampled receive path, sticky error flags.
- Sits between the processor-side valid/ready streams and the uart_external_connection pins.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_fifo_core_if.sv | 31 +++
 rtl/uart_sync_fifo.sv | 56 +++++
 rtl/uart_fifo_core.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants, FSM state codes and parity helper for the UART FIFO core.
package uart_pkg;

    localparam int OVERSAMPLE   = 16;
    localparam int SAMPLE_POINT = 8;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    typedef logic [2:0] tx_state_t;
    localparam tx_state_t TX_IDLE   = 3'd0;
    localparam tx_state_t TX_START  = 3'd1;
    localparam tx_state_t TX_DATA   = 3'd2;
    localparam tx_state_t TX_PARITY = 3'd3;
    localparam tx_state_t TX_STOP   = 3'd4;

    typedef logic [2:0] rx_state_t;
    localparam rx_state_t RX_IDLE   = 3'd0;
    localparam rx_state_t RX_START  = 3'd1;
    localparam rx_state_t RX_DATA   = 3'd2;
    localparam rx_state_t RX_PARITY = 3'd3;
    localparam rx_state_t RX_STOP   = 3'd4;

    // Narrow words are zero-extended by the caller; zeros do not change parity.
    function automatic logic f_par_bit(input logic [7:0] d, input logic [1:0] mode);
        case (mode)
            PAR_EVEN: return ^d;
            PAR_ODD:  return ~(^d);
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_fifo_core_if.sv
// Processor-side streams, FIFO levels and error flags of the UART FIFO core.
interface uart_fifo_core_if #(
    parameter int DATA_BITS = 8,
    parameter int TX_DEPTH  = 16,
    parameter int RX_DEPTH  = 16
);
    logic [DATA_BITS-1:0]      tx_data;
    logic                      tx_valid;
    logic                      tx_ready;
    logic [DATA_BITS-1:0]      rx_data;
    logic                      rx_valid;
    logic                      rx_ready;
    logic [$clog2(TX_DEPTH):0] tx_level;
    logic [$clog2(RX_DEPTH):0] rx_level;
    logic                      err_clr;
    logic                      rx_overrun;
    logic                      rx_parity_err;
    logic                      rx_frame_err;

    modport master (
        output tx_data, tx_valid, rx_ready, err_clr,
        input  tx_ready, rx_data, rx_valid, tx_level, rx_level,
               rx_overrun, rx_parity_err, rx_frame_err
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready, err_clr,
        output tx_ready, rx_data, rx_valid, tx_level, rx_level,
               rx_overrun, rx_parity_err, rx_frame_err
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with a registered first-word-fall-through head.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    output logic                   o_ready,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_valid,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int           AW     = $clog2(DEPTH);
    localparam logic [AW:0]  L_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [AW:0]      r_level;
    logic [WIDTH-1:0] r_head;
    logic             w_wr, w_rd;
    logic [AW-1:0]    w_rptr_nxt;
    logic [AW:0]      w_level_rem, w_level_nxt;

    assign o_valid     = (r_level != '0);
    assign o_ready     = (r_level != L_FULL);
    assign o_level     = r_level;
    assign o_data      = r_head;
    assign w_rd        = i_pop && o_valid;
    assign w_wr        = i_push && (o_ready || w_rd);
    assign w_rptr_nxt  = r_rptr + AW'(w_rd);
    assign w_level_rem = r_level - (AW+1)'(w_rd);
    assign w_level_nxt = w_level_rem + (AW+1)'(w_wr);

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= i_data;
    end

    // The head is preloaded so it is valid the same cycle o_valid rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_head  <= '0;
        end else begin
            r_wptr  <= r_wptr + AW'(w_wr);
            r_rptr  <= w_rptr_nxt;
            r_level <= w_level_nxt;
            if (w_level_nxt != '0)
                r_head <= (w_level_rem == '0) ? i_data : r_mem[w_rptr_nxt];
        end
    end
endmodule

// File: rtl/uart_fifo_core.sv
// UART core with TX/RX FIFOs, configurable frame and 16x oversampled receiver.
// Optional RTS/CTS flow control is enabled by defining UART_RTS_CTS_EN.
module uart_fifo_core import uart_pkg::*; #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int BAUD_DIV  = 27,
    parameter int TX_DEPTH  = 16,
    parameter int RX_DEPTH  = 16
) (
    input  logic            clk_clk,
    input  logic            reset_reset_n,
    uart_fifo_core_if.slave bus,
    input  logic            uart_external_connection_rxd,
    output logic            uart_external_connection_txd
`ifdef UART_RTS_CTS_EN
    ,
    input  logic            cts_n,
    output logic            rts_n
`endif
);
    localparam logic [1:0] PAR_MODE = 2'(PARITY);
    localparam int         BW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [1:0]           r_rst_sync;
    logic                 w_rst_n;
    logic [BW-1:0]        r_baud;
    logic                 w_tick, w_cts_ok;
    logic                 w_txf_pop, w_txf_valid, w_tx_go, w_tx_end, w_load;
    logic [DATA_BITS-1:0] w_txf_data;
    tx_state_t            r_tx_state, w_tx_state_nxt;
    logic [3:0]           r_tx_os, w_tx_os_nxt, r_tx_bit, w_tx_bit_nxt;
    logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_nxt;
    logic                 r_tx_par, w_tx_par_nxt, r_txd, w_txd_nxt;
    rx_state_t            r_rx_state;
    logic [1:0]           r_rx_sync;
    logic                 r_rx_prev, w_rxd, w_rx_fall, w_rx_samp, w_rx_push;
    logic [3:0]           r_rx_os, r_rx_bit;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 r_rx_par, w_rxf_ready, w_par_bad;
    logic                 r_ovr, r_perr, r_ferr;

    // Reset asserts asynchronously and releases on a clock edge.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) r_rst_sync <= 2'b00;
        else                r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    always_ff @(posedge clk_clk or negedge w_rst_n) begin
        if (!w_rst_n)    r_baud <= '0;
        else if (w_tick) r_baud <= '0;
        else             r_baud <= r_baud + BW'(1);
    end
    assign w_tick = (r_baud == BW'(BAUD_DIV-1));

`ifdef UART_RTS_CTS_EN
    logic [1:0] r_cts_sync;
    logic       r_rts_n;
    always_ff @(posedge clk_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_cts_sync <= 2'b11;
            r_rts_n    <= 1'b1;
        end else begin
            r_cts_sync <= {r_cts_sync[0], cts_n};
            r_rts_n    <= (bus.rx_level >= ($clog2(RX_DEPTH)+1)'(RX_DEPTH-2));
        end
    end
    assign w_cts_ok = !r_cts_sync[1];
    assign rts_n    = r_rts_n;
`else
    assign w_cts_ok = 1'b1;
`endif

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk_clk), .rst_n(w_rst_n),
        .i_push(bus.tx_valid && bus.tx_ready), .i_data(bus.tx_data), .o_ready(bus.tx_ready),
        .i_pop(w_txf_pop), .o_data(w_txf_data), .o_valid(w_txf_valid), .o_level(bus.tx_level)
    );

    assign w_tx_go  = w_tick && w_txf_valid && w_cts_ok;
    assign w_tx_end = w_tick && (r_tx_os == 4'(OVERSAMPLE-1));

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_os_nxt    = (r_tx_state != TX_IDLE && w_tick) ? r_tx_os + 4'd1 : r_tx_os;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_par_nxt   = r_tx_par;
        w_txf_pop      = 1'b0;
        w_load         = 1'b0;
        case (r_tx_state)
            TX_IDLE:  w_load = w_tx_go;
            TX_START: if (w_tx_end) begin
                w_tx_state_nxt = TX_DATA;
                w_tx_bit_nxt   = '0;
            end
            TX_DATA: if (w_tx_end) begin
                w_tx_shift_nxt = r_tx_shift >> 1;
                if (r_tx_bit == 4'(DATA_BITS-1)) begin
                    w_tx_state_nxt = (PAR_MODE != PAR_NONE) ? TX_PARITY : TX_STOP;
                    w_tx_bit_nxt   = '0;
                end else begin
                    w_tx_bit_nxt   = r_tx_bit + 4'd1;
                end
            end
            TX_PARITY: if (w_tx_end) begin
                w_tx_state_nxt = TX_STOP;
                w_tx_bit_nxt   = '0;
            end
            TX_STOP: if (w_tx_end) begin
                if (r_tx_bit == 4'(STOP_BITS-1)) begin
                    w_tx_state_nxt = TX_IDLE;
                    w_load         = w_tx_go;
                end else begin
                    w_tx_bit_nxt   = r_tx_bit + 4'd1;
                end
            end
            default: w_tx_state_nxt = TX_IDLE;
        endcase
        // Loading from STOP gives back-to-back frames without an idle gap.
        if (w_load) begin
            w_txf_pop      = 1'b1;
            w_tx_state_nxt = TX_START;
            w_tx_os_nxt    = '0;
            w_tx_shift_nxt = w_txf_data;
            w_tx_par_nxt   = f_par_bit(8'(w_txf_data), PAR_MODE);
        end
        case (w_tx_state_nxt)
            TX_START:  w_txd_nxt = 1'b0;
            TX_DATA:   w_txd_nxt = w_tx_shift_nxt[0];
            TX_PARITY: w_txd_nxt = w_tx_par_nxt;
            default:   w_txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_os    <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_txd      <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_os    <= w_tx_os_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx_par   <= w_tx_par_nxt;
            r_txd      <= w_txd_nxt;
        end
    end
    assign uart_external_connection_txd = r_txd;

    assign w_rxd     = r_rx_sync[1];
    assign w_rx_fall = r_rx_prev && !w_rxd;
    // The eighth tick after a bit edge lands in the middle of the bit.
    assign w_rx_samp = w_tick && (r_rx_os == 4'(SAMPLE_POINT-1));
    assign w_rx_push = (r_rx_state == RX_STOP) && w_rx_samp;
    assign w_par_bad = (PAR_MODE != PAR_NONE) && (r_rx_par != f_par_bit(8'(r_rx_shift), PAR_MODE));

    always_ff @(posedge clk_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rx_sync  <= 2'b11;
            r_rx_prev  <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_os    <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_par   <= 1'b0;
        end else begin
            r_rx_sync <= {r_rx_sync[0], uart_external_connection_rxd};
            r_rx_prev <= w_rxd;
            if (r_rx_state != RX_IDLE && w_tick) r_rx_os <= r_rx_os + 4'd1;
            case (r_rx_state)
                RX_IDLE: if (w_rx_fall) begin
                    r_rx_state <= RX_START;
                    r_rx_os    <= '0;
                end
                RX_START: if (w_rx_samp) begin
                    r_rx_state <= w_rxd ? RX_IDLE : RX_DATA;
                    r_rx_bit   <= '0;
                end
                RX_DATA: if (w_rx_samp) begin
                    r_rx_shift <= {w_rxd, r_rx_shift[DATA_BITS-1:1]};
                    if (r_rx_bit == 4'(DATA_BITS-1))
                        r_rx_state <= (PAR_MODE != PAR_NONE) ? RX_PARITY : RX_STOP;
                    else
                        r_rx_bit   <= r_rx_bit + 4'd1;
                end
                RX_PARITY: if (w_rx_samp) begin
                    r_rx_par   <= w_rxd;
                    r_rx_state <= RX_STOP;
                end
                RX_STOP: if (w_rx_samp) r_rx_state <= RX_IDLE;
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk_clk), .rst_n(w_rst_n),
        .i_push(w_rx_push), .i_data(r_rx_shift), .o_ready(w_rxf_ready),
        .i_pop(bus.rx_ready), .o_data(bus.rx_data), .o_valid(bus.rx_valid), .o_level(bus.rx_level)
    );

    // A new error event wins over a same-cycle clear.
    always_ff @(posedge clk_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_ovr  <= 1'b0;
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            r_ovr  <= (r_ovr  && !bus.err_clr) ||
                      (w_rx_push && !w_rxf_ready && !(bus.rx_ready && bus.rx_valid));
            r_perr <= (r_perr && !bus.err_clr) || (w_rx_push && w_par_bad);
            r_ferr <= (r_ferr && !bus.err_clr) || (w_rx_push && !w_rxd);
        end
    end
    assign bus.rx_overrun    = r_ovr;
    assign bus.rx_parity_err = r_perr;
    assign bus.rx_frame_err  = r_ferr;
endmodule
